// File: rtl/orb_pkg.sv
// Shared constants and types for the orbit ping-pong frame buffer.
// Holds default widths/depth and the writer-side state encoding.
package orb_pkg;

    localparam int ORB_DATA_W      = 12;
    localparam int ORB_FRAME_DEPTH = 2048;

    // Writer bank state: still being filled, or holding a complete frame
    typedef enum logic {
        FILLING = 1'b0,
        READY   = 1'b1
    } wrState_t;

endpackage

// File: rtl/orb_dpram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Ports: clk; we/waddr/wdata write; re/raddr read; rdata (1-cycle latency).
module orb_dpram
    import orb_pkg::*;
#(
    parameter int DATA_W = ORB_DATA_W,
    parameter int DEPTH  = ORB_FRAME_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on array or output register so this maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/orb_pingpong_buf.sv
// Ping-pong frame buffer between the LCB word packer and orbit serializer.
// Ports: clk, rst (sync, active-high); wr_* write side with wr_frame_done;
//   rd_* read side with rd_swap frame boundary; rd_bank, frame_fresh,
//   repeat_p, overrun_p status; repeat_cnt, missed_cnt statistics.
// Build option: ORB_PP_STATS_EN enables the saturating statistics counters;
//   when undefined both counters read 0 and no counter logic exists.
module orb_pingpong_buf
    import orb_pkg::*;
#(
    parameter int DATA_W = ORB_DATA_W,
    parameter int DEPTH  = ORB_FRAME_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_frame_done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_swap,
    output logic              rd_bank,
    output logic              frame_fresh,
    output logic              repeat_p,
    output logic              overrun_p,
    output logic [CNT_W-1:0]  repeat_cnt,
    output logic [CNT_W-1:0]  missed_cnt
);

    localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];

    wrState_t          wrState;
    logic              wrOk;
    logic              rdOk;
    logic              frameAvail;
    logic              swapTake;
    logic              swapRefuse;
    logic              frameOnly;
    logic              rdSel;
    logic              rdZero;
    logic [DATA_W-1:0] q0;
    logic [DATA_W-1:0] q1;

    // Out-of-range addresses never reach the RAMs
    assign wrOk = wr_en && ({1'b0, wr_addr} < DEPTH_V);
    assign rdOk = rd_en && ({1'b0, rd_addr} < DEPTH_V);

    // A frame completing in the swap cycle is handed over immediately
    assign frameAvail = (wrState == READY) || wr_frame_done;
    assign swapTake   = rd_swap && frameAvail;
    assign swapRefuse = rd_swap && !frameAvail;
    assign frameOnly  = wr_frame_done && !rd_swap;

    // Write bank is always the one not being read
    orb_dpram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) uBank0 (
        .clk   (clk),
        .we    (wrOk && rd_bank),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (rdOk && !rd_bank),
        .raddr (rd_addr),
        .rdata (q0)
    );

    orb_dpram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) uBank1 (
        .clk   (clk),
        .we    (wrOk && !rd_bank),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (rdOk && rd_bank),
        .raddr (rd_addr),
        .rdata (q1)
    );

    // Output steering is captured only on rd_en so rd_data holds between
    // reads; rdZero also supplies the reset value and out-of-range zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rdSel    <= 1'b0;
            rdZero   <= 1'b1;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rdSel  <= rd_bank;
                rdZero <= !rdOk;
            end
        end
    end

    assign rd_data = rdZero ? '0 : (rdSel ? q1 : q0);

    // Writer FSM and bank swap control
    always_ff @(posedge clk) begin
        if (rst) begin
            wrState     <= FILLING;
            rd_bank     <= 1'b0;
            frame_fresh <= 1'b0;
            repeat_p    <= 1'b0;
            overrun_p   <= 1'b0;
        end else begin
            repeat_p  <= 1'b0;
            overrun_p <= 1'b0;
            unique case (1'b1)
                swapTake: begin
                    rd_bank     <= ~rd_bank;
                    frame_fresh <= 1'b1;
                    wrState     <= FILLING;
                end
                swapRefuse: begin
                    frame_fresh <= 1'b0;
                    repeat_p    <= 1'b1;
                end
                frameOnly: begin
                    // Newer frame overwrites a pending one
                    overrun_p <= (wrState == READY);
                    wrState   <= READY;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ORB_PP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            repeat_cnt <= '0;
            missed_cnt <= '0;
        end else begin
            if (repeat_p && (repeat_cnt != '1)) begin
                repeat_cnt <= repeat_cnt + 1'b1;
            end
            if (overrun_p && (missed_cnt != '1)) begin
                missed_cnt <= missed_cnt + 1'b1;
            end
        end
    end
`else
    assign repeat_cnt = '0;
    assign missed_cnt = '0;
`endif

endmodule

// File: tb/tb_orb_pingpong_buf.sv
// Self-checking bench for orb_pingpong_buf: directed plan plus random traffic
// compared against a frame-level reference model.
module tb_orb_pingpong_buf;

    localparam int DW  = 12;
    localparam int DEP = 20;
    localparam int AW  = 5;
    localparam int CW  = 8;
`ifdef ORB_PP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_frame_done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_swap;
    logic          rd_bank;
    logic          frame_fresh;
    logic          repeat_p;
    logic          overrun_p;
    logic [CW-1:0] repeat_cnt;
    logic [CW-1:0] missed_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] mMem [2][DEP];
    int            mBank;
    bit            mPend;
    bit            mFresh;
    bit            mRep;
    bit            mOvr;
    int            mRepCnt;
    int            mMisCnt;
    bit            mRdValid;
    logic [DW-1:0] mRdData;

    always #5 clk = ~clk;

    orb_pingpong_buf #(
        .DATA_W (DW),
        .DEPTH  (DEP),
        .ADDR_W (AW),
        .CNT_W  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_frame_done (wr_frame_done),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_swap       (rd_swap),
        .rd_bank       (rd_bank),
        .frame_fresh   (frame_fresh),
        .repeat_p      (repeat_p),
        .overrun_p     (overrun_p),
        .repeat_cnt    (repeat_cnt),
        .missed_cnt    (missed_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        chk("rd_valid", 32'(rd_valid), 32'(mRdValid));
        chk("rd_data", 32'(rd_data), 32'(mRdData));
        chk("rd_bank", 32'(rd_bank), 32'(mBank));
        chk("frame_fresh", 32'(frame_fresh), 32'(mFresh));
        chk("repeat_p", 32'(repeat_p), 32'(mRep));
        chk("overrun_p", 32'(overrun_p), 32'(mOvr));
        chk("repeat_cnt", 32'(repeat_cnt), STATS ? 32'(mRepCnt) : 32'd0);
        chk("missed_cnt", 32'(missed_cnt), STATS ? 32'(mMisCnt) : 32'd0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        wr_en = 1'b0;
        wr_frame_done = 1'b0;
        rd_en = 1'b0;
        rd_swap = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mBank = 0;
        mPend = 1'b0;
        mFresh = 1'b0;
        mRep = 1'b0;
        mOvr = 1'b0;
        mRepCnt = 0;
        mMisCnt = 0;
        mRdValid = 1'b0;
        mRdData = '0;
        checkAll();
    endtask

    // One clock cycle: drive inputs, advance the model, compare after edge
    task automatic step(input bit we, input int wa, input logic [DW-1:0] wd,
                        input bit fd, input bit sw, input bit re,
                        input int ra);
        bit avail;
        wr_en = we;
        wr_addr = AW'(wa);
        wr_data = wd;
        wr_frame_done = fd;
        rd_swap = sw;
        rd_en = re;
        rd_addr = AW'(ra);
        mRdValid = re;
        if (re) begin
            mRdData = (ra < DEP) ? mMem[mBank][ra] : '0;
        end
        if (we && wa < DEP) begin
            mMem[1 - mBank][wa] = wd;
        end
        if (mRep && mRepCnt < 255) mRepCnt++;
        if (mOvr && mMisCnt < 255) mMisCnt++;
        avail = mPend || fd;
        mOvr = fd && mPend && !sw;
        mRep = sw && !avail;
        if (sw && avail) begin
            mBank = 1 - mBank;
            mFresh = 1'b1;
            mPend = 1'b0;
        end else begin
            if (sw) mFresh = 1'b0;
            mPend = avail;
        end
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, 0, 0);
    endtask

    initial begin
        doReset();

        // Fill both banks so every later read has a defined value
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < DEP; a++) begin
                step(1, a, DW'($urandom), 0, 0, 0, 0);
            end
            step(0, 0, '0, 1, 0, 0, 0);
            step(0, 0, '0, 0, 1, 0, 0);
        end
        doReset();

        // Read straight after reset
        step(0, 0, '0, 0, 0, 1, 5);
        chk("plan_rd_valid", 32'(rd_valid), 32'd1);
        chk("plan_rst_bank", 32'(rd_bank), 32'd0);

        // Write, complete, swap, read back
        step(1, 5, 12'hABC, 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0);
        step(0, 0, '0, 0, 1, 0, 0);
        step(0, 0, '0, 0, 0, 1, 5);
        chk("plan_swap_bank", 32'(rd_bank), 32'd1);
        chk("plan_swap_fresh", 32'(frame_fresh), 32'd1);
        chk("plan_swap_data", 32'(rd_data), 32'hABC);

        // Refused swap
        step(0, 0, '0, 0, 1, 0, 0);
        chk("plan_repeat_p", 32'(repeat_p), 32'd1);
        chk("plan_repeat_bank", 32'(rd_bank), 32'd1);
        chk("plan_repeat_fresh", 32'(frame_fresh), 32'd0);
        idle();
        chk("plan_repeat_cnt", 32'(repeat_cnt), STATS ? 32'd1 : 32'd0);

        // Overrun
        step(0, 0, '0, 1, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0);
        chk("plan_overrun_p", 32'(overrun_p), 32'd1);
        idle();
        chk("plan_missed_cnt", 32'(missed_cnt), STATS ? 32'd1 : 32'd0);
        step(0, 0, '0, 0, 1, 0, 0);
        chk("plan_overrun_swap", 32'(rd_bank), 32'd0);

        // Frame done, swap and write together
        step(1, 7, 12'h123, 1, 1, 0, 0);
        chk("plan_same_bank", 32'(rd_bank), 32'd1);
        chk("plan_same_ovr", 32'(overrun_p), 32'd0);
        step(0, 0, '0, 0, 0, 1, 7);
        chk("plan_same_data", 32'(rd_data), 32'h123);

        // Out-of-range read returns zero
        step(0, 0, '0, 0, 0, 1, 25);
        chk("plan_oor_valid", 32'(rd_valid), 32'd1);
        chk("plan_oor_data", 32'(rd_data), 32'd0);

        // Reset discards a pending frame
        step(0, 0, '0, 1, 0, 0, 0);
        doReset();
        step(0, 0, '0, 0, 1, 0, 0);
        chk("plan_rst_repeat", 32'(repeat_p), 32'd1);
        chk("plan_rst_noswap", 32'(rd_bank), 32'd0);

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            step(0, 0, '0, 0, 1, 0, 0);
        end
        idle();
        chk("plan_sat", 32'(repeat_cnt), STATS ? 32'd255 : 32'd0);

        // Random traffic
        doReset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 31)), DW'($urandom),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 31)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/orb_pingpong_buf.md
# orb_pingpong_buf

Parametrised single-clock ping-pong frame buffer between the LCB word packer (write side) and the orbit frame serializer (read side). Holds two banks of DEPTH words of DATA_W bits; the reader always reads one bank while the packer fills the other. Banks swap only on a reader frame boundary and only if the packer has declared a complete frame; otherwise the reader repeats the old frame and the event is flagged.

## Interface
Parameters:
- DATA_W, 12, orbit word width
- DEPTH, 2048, words per bank; need not be a power of two
- ADDR_W, $clog2(DEPTH), address width (derived)
- CNT_W, 8, width of the saturating statistics counters

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock (80 MHz domain)
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write strobe into the write bank
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_frame_done  in  1  one-cycle pulse: write bank holds a complete frame
- rd_en  in  1  read strobe from the read bank
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data valid
- rd_swap  in  1  one-cycle pulse at the reader frame boundary
- rd_bank  out  1  bank currently being read (write bank = ~rd_bank)
- frame_fresh  out  1  read bank holds a frame not read before
- repeat_p  out  1  one-cycle pulse: swap refused, old frame repeats
- overrun_p  out  1  one-cycle pulse: frame completed while another frame was still pending
- repeat_cnt  out  CNT_W  repeated-frame count (see Configuration)
- missed_cnt  out  CNT_W  overrun count (see Configuration)

## Operation
- Writer FSM, two states: FILLING, READY. Reset enters FILLING.
- FILLING + wr_frame_done -> READY.
- READY + wr_frame_done without rd_swap -> stay READY, overrun_p=1. The bank now holds the newer frame; the older frame is lost.
- On rd_swap in READY: toggle rd_bank, frame_fresh<=1, FSM -> FILLING.
- On rd_swap in FILLING: rd_bank unchanged, frame_fresh<=0, repeat_p=1.
- rd_swap and wr_frame_done in the same cycle: wr_frame_done is taken first. The swap proceeds with the just-completed frame, FSM -> FILLING, no overrun.
- A write in the swap cycle goes to the pre-swap write bank. Writes in FILLING and READY are both accepted.
- A read uses the rd_bank value sampled in the rd_en cycle.
- Addresses >= DEPTH: the write is dropped; the read returns 0 with rd_valid=1.
- Bank contents are not cleared by reset.

## Timing
- Reset values: rd_data=0, rd_valid=0, rd_bank=0, frame_fresh=0, repeat_p=0, overrun_p=0, repeat_cnt=0, missed_cnt=0.
- Write: data is visible to a read of the same bank starting the cycle after wr_en.
- Read latency is 1 cycle: rd_en at cycle N gives rd_data and rd_valid=1 at N+1. rd_valid=0 when the previous cycle had no rd_en. rd_data holds its last value when rd_valid=0.
- rd_bank, frame_fresh, repeat_p and overrun_p are registered and change the cycle after the causing pulse.
- rst asserted mid-frame aborts everything: the FSM goes to FILLING and a pending READY frame is discarded.

## Configuration
- Macro ORB_PP_STATS_EN.
- Defined: repeat_cnt increments on each repeat_p and missed_cnt on each overrun_p. Both saturate at 2^CNT_W-1 and clear only on rst.
- Undefined: both counters are tied to 0 and no counter logic is synthesised. Pulses and all other behaviour are unchanged.

## Structure
- Shared package orb_pkg holds ORB_DATA_W=12, ORB_FRAME_DEPTH=2048, and the writer-state enum (FILLING, READY).
- One sub-module, orb_dpram: simple dual-port RAM with one write port and one registered read port, 1-cycle latency. It is instantiated twice, one per bank, and maps to block RAM.
- Bank steering, the writer FSM and the statistics counters live in the top module.

## Test plan
- Reset, then read address 5 -> rd_valid=1 one cycle later; rd_bank=0, frame_fresh=0, all counters 0.
- Write 0xABC at address 5, pulse wr_frame_done, pulse rd_swap, then read address 5 -> rd_bank=1, frame_fresh=1, rd_data=0xABC at 1-cycle latency.
- Pulse rd_swap with no wr_frame_done -> repeat_p pulse, rd_bank unchanged, frame_fresh=0, repeat_cnt=1 (macro defined) or 0 (undefined).
- Pulse wr_frame_done twice before rd_swap -> one overrun_p pulse, missed_cnt=1; the next rd_swap still swaps.
- Assert rd_swap, wr_frame_done and wr_en (address 7, 0x123) in the same cycle -> swap occurs, no overrun; 0x123 is readable at address 7 from the new read bank.
- Apply rst while READY, then pulse rd_swap -> repeat_p=1, no swap. Drive 300 repeats with CNT_W=8 -> repeat_cnt saturates at 255.
